// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Control unit for a multicycle CPU. Each instruction is stepped through
// IF/ID/EXE/MEM/WB, and this block drives every datapath strobe and select.
// State is registered. Outputs are combinational from the state plus op/funct.
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   -> an unknown opcode/funct halts the machine and raises illegal
//   undefined -> an unknown opcode/funct runs as a nop and illegal is tied 0
module multicycle_control_fsm #(
  parameter int                OPW     = 6,
  parameter logic [OPW-1:0]    HALT_OP = '1
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] op,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  output logic [2:0]     state,
  output logic           PCWre,
  output logic           IRWre,
  output logic           RegWre,
  output logic [1:0]     RegDst,
  output logic           ALUSrcB,
  output logic           ExtSel,
  output logic [2:0]     ALUOp,
  output logic           mRD,
  output logic           mWR,
  output logic           DBDataSrc,
  output logic           WrRegDSrc,
  output logic [1:0]     PCSrc,
  output logic           illegal
);

  // Opcode and funct encodings
  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b000011);

  localparam logic [OPW-1:0] FN_ADD  = OPW'(6'b100000);
  localparam logic [OPW-1:0] FN_SUB  = OPW'(6'b100010);
  localparam logic [OPW-1:0] FN_AND  = OPW'(6'b100100);
  localparam logic [OPW-1:0] FN_OR   = OPW'(6'b100101);
  localparam logic [OPW-1:0] FN_JR   = OPW'(6'b001000);

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // PC source selects
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // Register destination selects
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  // Instruction classes seen by the sequencer
  typedef enum logic [3:0] {
    C_ALU_R,
    C_ADDI,
    C_ORI,
    C_LW,
    C_SW,
    C_BEQ,
    C_J,
    C_JAL,
    C_JR,
    C_HALT,
    C_BAD
  } cls_e;

  // All control outputs gathered so the reset gating is one assignment
  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       alu_src_b;
    logic       ext_sel;
    logic [2:0] alu_op;
    logic       m_rd;
    logic       m_wr;
    logic       db_data_src;
    logic       wr_reg_d_src;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

  state_e     state_q, state_d;
  logic       halt_q, halt_d;
  cls_e       cls;
  logic [2:0] alu_r_op;
  logic [2:0] alu_sel;
  ctrl_t      ctrl_c;
  ctrl_t      ctrl_o;

`ifdef ILLEGAL_TRAP_EN
  logic       illegal_q, illegal_d;
`endif

  // Classify the current instruction from op/funct and pick the R-type ALU op
  always_comb begin
    cls      = C_BAD;
    alu_r_op = ALU_ADD;
    if (op == HALT_OP) begin
      cls = C_HALT;
    end else begin
      case (op)
        OP_R: begin
          case (funct)
            FN_ADD: begin cls = C_ALU_R; alu_r_op = ALU_ADD; end
            FN_SUB: begin cls = C_ALU_R; alu_r_op = ALU_SUB; end
            FN_AND: begin cls = C_ALU_R; alu_r_op = ALU_AND; end
            FN_OR:  begin cls = C_ALU_R; alu_r_op = ALU_OR;  end
            FN_JR:  cls = C_JR;
            default: cls = C_BAD;
          endcase
        end
        OP_ADDI: cls = C_ADDI;
        OP_ORI:  cls = C_ORI;
        OP_LW:   cls = C_LW;
        OP_SW:   cls = C_SW;
        OP_BEQ:  cls = C_BEQ;
        OP_J:    cls = C_J;
        OP_JAL:  cls = C_JAL;
        default: cls = C_BAD;
      endcase
    end
  end

  // ALU op used during EXE_AL and held through WB_AL
  always_comb begin
    alu_sel = ALU_ADD;
    case (cls)
      C_ALU_R: alu_sel = alu_r_op;
      C_ADDI:  alu_sel = ALU_ADD;
      C_ORI:   alu_sel = ALU_OR;
      default: alu_sel = ALU_ADD;
    endcase
  end

  // Next-state and control outputs for the current state
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    ctrl_c  = '0;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    if (halt_q) begin
      // Halted: stay in ID and keep every strobe low until reset.
      state_d = S_ID;
`ifdef ILLEGAL_TRAP_EN
      ctrl_c.illegal = illegal_q;
`endif
    end else begin
      case (state_q)
        S_IF: begin
          ctrl_c.ir_wre = 1'b1;
          state_d       = S_ID;
        end

        S_ID: begin
          case (cls)
            C_J: begin
              ctrl_c.pc_wre = 1'b1;
              ctrl_c.pc_src = PC_JUMP;
              state_d       = S_IF;
            end
            C_JAL: begin
              ctrl_c.pc_wre       = 1'b1;
              ctrl_c.pc_src       = PC_JUMP;
              ctrl_c.reg_wre      = 1'b1;
              ctrl_c.reg_dst      = DST_RA;
              ctrl_c.wr_reg_d_src = 1'b0;
              state_d             = S_IF;
            end
            C_JR: begin
              ctrl_c.pc_wre = 1'b1;
              ctrl_c.pc_src = PC_RS;
              state_d       = S_IF;
            end
            C_HALT: begin
              halt_d  = 1'b1;
              state_d = S_ID;
            end
            C_BEQ:                   state_d = S_EXE_BR;
            C_LW, C_SW:              state_d = S_EXE_LS;
            C_ALU_R, C_ADDI, C_ORI:  state_d = S_EXE_AL;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              // Trap: freeze in ID and flag the bad instruction.
              halt_d         = 1'b1;
              illegal_d      = 1'b1;
              ctrl_c.illegal = 1'b1;
              state_d        = S_ID;
`else
              // Treat the unknown encoding as a nop and move to the next PC.
              ctrl_c.pc_wre = 1'b1;
              ctrl_c.pc_src = PC_PLUS4;
              state_d       = S_IF;
`endif
            end
          endcase
        end

        S_EXE_AL: begin
          ctrl_c.alu_op    = alu_sel;
          ctrl_c.alu_src_b = (cls != C_ALU_R);
          ctrl_c.ext_sel   = (cls == C_ADDI);
          state_d          = S_WB_AL;
        end

        S_WB_AL: begin
          ctrl_c.alu_op       = alu_sel;
          ctrl_c.alu_src_b    = (cls != C_ALU_R);
          ctrl_c.ext_sel      = (cls == C_ADDI);
          ctrl_c.reg_wre      = 1'b1;
          ctrl_c.reg_dst      = (cls == C_ALU_R) ? DST_RD : DST_RT;
          ctrl_c.pc_wre       = 1'b1;
          ctrl_c.pc_src       = PC_PLUS4;
          ctrl_c.db_data_src  = 1'b0;
          ctrl_c.wr_reg_d_src = 1'b1;
          state_d             = S_IF;
        end

        S_EXE_BR: begin
          ctrl_c.alu_op    = ALU_SUB;
          ctrl_c.alu_src_b = 1'b0;
          ctrl_c.pc_wre    = 1'b1;
          ctrl_c.pc_src    = zero ? PC_BRANCH : PC_PLUS4;
          state_d          = S_IF;
        end

        S_EXE_LS: begin
          ctrl_c.alu_op    = ALU_ADD;
          ctrl_c.alu_src_b = 1'b1;
          ctrl_c.ext_sel   = 1'b1;
          state_d          = S_MEM;
        end

        S_MEM: begin
          if (cls == C_LW) begin
            ctrl_c.m_rd = 1'b1;
            state_d     = S_WB_LD;
          end else begin
            ctrl_c.m_wr   = 1'b1;
            ctrl_c.pc_wre = 1'b1;
            ctrl_c.pc_src = PC_PLUS4;
            state_d       = S_IF;
          end
        end

        S_WB_LD: begin
          ctrl_c.reg_wre      = 1'b1;
          ctrl_c.reg_dst      = DST_RT;
          ctrl_c.db_data_src  = 1'b1;
          ctrl_c.wr_reg_d_src = 1'b1;
          ctrl_c.pc_wre       = 1'b1;
          ctrl_c.pc_src       = PC_PLUS4;
          state_d             = S_IF;
        end

        default: state_d = S_IF;
      endcase
    end
  end

  // State register and halt flag; reset aborts any instruction in flight
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IF;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal-instruction flag, cleared only by reset
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
`endif

  // Hold every output low while reset is asserted, even though state reads IF
  always_comb begin
    ctrl_o = Reset ? ctrl_c : '0;
  end

  assign state     = state_q;
  assign PCWre     = ctrl_o.pc_wre;
  assign IRWre     = ctrl_o.ir_wre;
  assign RegWre    = ctrl_o.reg_wre;
  assign RegDst    = ctrl_o.reg_dst;
  assign ALUSrcB   = ctrl_o.alu_src_b;
  assign ExtSel    = ctrl_o.ext_sel;
  assign ALUOp     = ctrl_o.alu_op;
  assign mRD       = ctrl_o.m_rd;
  assign mWR       = ctrl_o.m_wr;
  assign DBDataSrc = ctrl_o.db_data_src;
  assign WrRegDSrc = ctrl_o.wr_reg_d_src;
  assign PCSrc     = ctrl_o.pc_src;
  assign illegal   = ctrl_o.illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
// Directed bench for multicycle_control_fsm. Each cycle, all outputs are packed
// into one 20-bit word. That word is compared with a hand-built expected word:
// {state, PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, ALUOp,
//  mRD, mWR, DBDataSrc, WrRegDSrc, PCSrc, illegal}
// Build with or without ILLEGAL_TRAP_EN. The unknown-opcode section adapts to the build.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic [2:0] state;
  logic       pc_wre, ir_wre, reg_wre, alu_src_b, ext_sel;
  logic       m_rd, m_wr, db_data_src, wr_reg_d_src, illegal;
  logic [1:0] reg_dst, pc_src;
  logic [2:0] alu_op;
  logic [19:0] obs;

  int checks;
  int errors;

  multicycle_control_fsm #(.OPW(6), .HALT_OP(6'b111111)) dut (
    .CLK       (clk),
    .Reset     (reset_n),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .state     (state),
    .PCWre     (pc_wre),
    .IRWre     (ir_wre),
    .RegWre    (reg_wre),
    .RegDst    (reg_dst),
    .ALUSrcB   (alu_src_b),
    .ExtSel    (ext_sel),
    .ALUOp     (alu_op),
    .mRD       (m_rd),
    .mWR       (m_wr),
    .DBDataSrc (db_data_src),
    .WrRegDSrc (wr_reg_d_src),
    .PCSrc     (pc_src),
    .illegal   (illegal)
  );

  assign obs = {state, pc_wre, ir_wre, reg_wre, reg_dst, alu_src_b, ext_sel,
                alu_op, m_rd, m_wr, db_data_src, wr_reg_d_src, pc_src, illegal};

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build an expected output word from individual field values
  function automatic logic [19:0] mk(input logic [2:0] st, input logic pcw,
                                     input logic irw, input logic regw,
                                     input logic [1:0] rd, input logic sb,
                                     input logic ex, input logic [2:0] alu,
                                     input logic mr, input logic mw,
                                     input logic dbs, input logic wrs,
                                     input logic [1:0] pcs, input logic ill);
    return {st, pcw, irw, regw, rd, sb, ex, alu, mr, mw, dbs, wrs, pcs, ill};
  endfunction

  // Compare one observed word against its expected value and count it
  task automatic checkOutput(input string tag, input logic [19:0] got,
                             input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Drive the instruction fields seen by the control unit
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input logic z);
    op    = o;
    funct = f;
    zero  = z;
  endtask

  // Check the current cycle just after the falling edge, then advance one cycle
  task automatic stepCheck(input string tag, input logic [19:0] exp);
    #1;
    checkOutput(tag, obs, exp);
    @(negedge clk);
  endtask

  logic [19:0] v_zero, v_if, v_id;

  initial begin
    checks  = 0;
    errors  = 0;
    v_zero  = mk(3'd0, 0,0,0, 2'b00, 0,0, 3'b000, 0,0,0,0, 2'b00, 0);
    v_if    = mk(3'd0, 0,1,0, 2'b00, 0,0, 3'b000, 0,0,0,0, 2'b00, 0);
    v_id    = mk(3'd1, 0,0,0, 2'b00, 0,0, 3'b000, 0,0,0,0, 2'b00, 0);

    // Reset held low for three cycles while an add is presented
    reset_n = 1'b0;
    applyStimulus(6'b000000, 6'b100000, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) stepCheck("reset_low", v_zero);
    reset_n = 1'b1;

    // add
    stepCheck("add_if", v_if);
    stepCheck("add_id", v_id);
    stepCheck("add_exe", mk(3'd6, 0,0,0, 2'b00, 0,0, 3'b000, 0,0,0,0, 2'b00, 0));
    stepCheck("add_wb",  mk(3'd7, 1,0,1, 2'b01, 0,0, 3'b000, 0,0,0,1, 2'b00, 0));

    // sub
    applyStimulus(6'b000000, 6'b100010, 1'b0);
    stepCheck("sub_if", v_if);
    stepCheck("sub_id", v_id);
    stepCheck("sub_exe", mk(3'd6, 0,0,0, 2'b00, 0,0, 3'b001, 0,0,0,0, 2'b00, 0));
    stepCheck("sub_wb",  mk(3'd7, 1,0,1, 2'b01, 0,0, 3'b001, 0,0,0,1, 2'b00, 0));

    // and, or: check the write-back cycle ALU op
    applyStimulus(6'b000000, 6'b100100, 1'b0);
    stepCheck("and_if", v_if);
    stepCheck("and_id", v_id);
    stepCheck("and_exe", mk(3'd6, 0,0,0, 2'b00, 0,0, 3'b010, 0,0,0,0, 2'b00, 0));
    stepCheck("and_wb",  mk(3'd7, 1,0,1, 2'b01, 0,0, 3'b010, 0,0,0,1, 2'b00, 0));
    applyStimulus(6'b000000, 6'b100101, 1'b0);
    stepCheck("or_if", v_if);
    stepCheck("or_id", v_id);
    stepCheck("or_exe", mk(3'd6, 0,0,0, 2'b00, 0,0, 3'b011, 0,0,0,0, 2'b00, 0));
    stepCheck("or_wb",  mk(3'd7, 1,0,1, 2'b01, 0,0, 3'b011, 0,0,0,1, 2'b00, 0));

    // addi: sign-extended immediate, rt destination
    applyStimulus(6'b001000, 6'b000000, 1'b0);
    stepCheck("addi_if", v_if);
    stepCheck("addi_id", v_id);
    stepCheck("addi_exe", mk(3'd6, 0,0,0, 2'b00, 1,1, 3'b000, 0,0,0,0, 2'b00, 0));
    stepCheck("addi_wb",  mk(3'd7, 1,0,1, 2'b00, 1,1, 3'b000, 0,0,0,1, 2'b00, 0));

    // ori: zero-extended immediate
    applyStimulus(6'b001101, 6'b000000, 1'b0);
    stepCheck("ori_if", v_if);
    stepCheck("ori_id", v_id);
    stepCheck("ori_exe", mk(3'd6, 0,0,0, 2'b00, 1,0, 3'b011, 0,0,0,0, 2'b00, 0));
    stepCheck("ori_wb",  mk(3'd7, 1,0,1, 2'b00, 1,0, 3'b011, 0,0,0,1, 2'b00, 0));

    // lw: five cycles
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    stepCheck("lw_if", v_if);
    stepCheck("lw_id", v_id);
    stepCheck("lw_exe", mk(3'd2, 0,0,0, 2'b00, 1,1, 3'b000, 0,0,0,0, 2'b00, 0));
    stepCheck("lw_mem", mk(3'd3, 0,0,0, 2'b00, 0,0, 3'b000, 1,0,0,0, 2'b00, 0));
    stepCheck("lw_wb",  mk(3'd4, 1,0,1, 2'b00, 0,0, 3'b000, 0,0,1,1, 2'b00, 0));

    // sw: four cycles, PC written in MEM
    applyStimulus(6'b101011, 6'b000000, 1'b0);
    stepCheck("sw_if", v_if);
    stepCheck("sw_id", v_id);
    stepCheck("sw_exe", mk(3'd2, 0,0,0, 2'b00, 1,1, 3'b000, 0,0,0,0, 2'b00, 0));
    stepCheck("sw_mem", mk(3'd3, 1,0,0, 2'b00, 0,0, 3'b000, 0,1,0,0, 2'b00, 0));

    // beq taken then not taken
    applyStimulus(6'b000100, 6'b000000, 1'b1);
    stepCheck("beq1_if", v_if);
    stepCheck("beq1_id", v_id);
    stepCheck("beq1_exe", mk(3'd5, 1,0,0, 2'b00, 0,0, 3'b001, 0,0,0,0, 2'b01, 0));
    applyStimulus(6'b000100, 6'b000000, 1'b0);
    stepCheck("beq0_if", v_if);
    stepCheck("beq0_id", v_id);
    stepCheck("beq0_exe", mk(3'd5, 1,0,0, 2'b00, 0,0, 3'b001, 0,0,0,0, 2'b00, 0));

    // j, jal, jr: finish in ID
    applyStimulus(6'b000010, 6'b000000, 1'b0);
    stepCheck("j_if", v_if);
    stepCheck("j_id", mk(3'd1, 1,0,0, 2'b00, 0,0, 3'b000, 0,0,0,0, 2'b11, 0));
    applyStimulus(6'b000011, 6'b000000, 1'b0);
    stepCheck("jal_if", v_if);
    stepCheck("jal_id", mk(3'd1, 1,0,1, 2'b10, 0,0, 3'b000, 0,0,0,0, 2'b11, 0));
    applyStimulus(6'b000000, 6'b001000, 1'b0);
    stepCheck("jr_if", v_if);
    stepCheck("jr_id", mk(3'd1, 1,0,0, 2'b00, 0,0, 3'b000, 0,0,0,0, 2'b10, 0));
    stepCheck("after_jr_if", v_if);

    // Unknown opcode
    applyStimulus(6'b010101, 6'b000000, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    stepCheck("bad_id", mk(3'd1, 0,0,0, 2'b00, 0,0, 3'b000, 0,0,0,0, 2'b00, 1));
    applyStimulus(6'b000000, 6'b100000, 1'b0);
    for (int i = 0; i < 3; i++)
      stepCheck("bad_hold", mk(3'd1, 0,0,0, 2'b00, 0,0, 3'b000, 0,0,0,0, 2'b00, 1));
    reset_n = 1'b0;
    stepCheck("bad_reset", v_zero);
    reset_n = 1'b1;
    stepCheck("bad_after_if", v_if);
`else
    stepCheck("bad_id", mk(3'd1, 1,0,0, 2'b00, 0,0, 3'b000, 0,0,0,0, 2'b00, 0));
    // Unknown R-type funct behaves the same way
    applyStimulus(6'b000000, 6'b111000, 1'b0);
    stepCheck("badfn_if", v_if);
    stepCheck("badfn_id", mk(3'd1, 1,0,0, 2'b00, 0,0, 3'b000, 0,0,0,0, 2'b00, 0));
    stepCheck("bad_after_if", v_if);
`endif

    // HALT: ID with every output low, held even when op changes
    applyStimulus(6'b111111, 6'b000000, 1'b0);
    stepCheck("halt_id", v_id);
    applyStimulus(6'b000000, 6'b100000, 1'b1);
    for (int i = 0; i < 3; i++) stepCheck("halt_hold", v_id);
    reset_n = 1'b0;
    stepCheck("halt_reset", v_zero);
    reset_n = 1'b1;
    stepCheck("halt_after_if", v_if);

    // Reset in the middle of lw aborts it; the next cycle is IF
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    stepCheck("abort_id", v_id);
    stepCheck("abort_exe", mk(3'd2, 0,0,0, 2'b00, 1,1, 3'b000, 0,0,0,0, 2'b00, 0));
    reset_n = 1'b0;
    stepCheck("abort_reset", v_zero);
    reset_n = 1'b1;
    stepCheck("abort_if", v_if);
    stepCheck("abort_id2", v_id);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
